// File: rtl/execution_unit_pkg.sv
// Shared types for the NAND CPU execution unit: ALU opcodes, RR/EX stage structs and widths.
// The optional EX-result bypass and early wakeup are selected with EXEC_FWD_EN in execution_unit.sv.
package nand_cpu_pkg;

  localparam int EU_DW        = 16;
  localparam int EU_ROB_AW    = 1;
  localparam int EU_NUM_D_REG = 8;
  localparam int EU_NUM_S_REG = 4;
  localparam int EU_DRA_W     = $clog2(EU_NUM_D_REG);
  localparam int EU_SRA_W     = $clog2(EU_NUM_S_REG);
  localparam int EU_RV_W      = 16;
  localparam int EU_IMM_W     = 6;
  localparam int EX_FLAG_W    = 2;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_NAND = 3'd5,
    ALU_SHL  = 3'd6,
    ALU_SHR  = 3'd7
  } AluOp;

  // Operands fully resolved in RR, on their way into the ALU / EX register.
  typedef struct packed {
    logic                 valid;
    logic [EU_ROB_AW-1:0] rob_addr;
    AluOp                 alu_op;
    logic [EU_DW-1:0]     a;
    logic [EU_DW-1:0]     b;
    logic [EU_DRA_W-1:0]  rw_addr;
    logic [EU_SRA_W-1:0]  rs_addr;
    logic [EU_RV_W-1:0]   rv_addr;
  } ex_stage_t;

  typedef struct packed {
    logic                 valid;
    logic [EU_ROB_AW-1:0] rob_addr;
    AluOp                 alu_op;
    logic                 use_rt;
    logic [EU_IMM_W-1:0]  immdt;
    logic [EU_DW-1:0]     ra_data;
    logic [EU_DW-1:0]     rt_data;
    logic [EU_DRA_W-1:0]  rw_addr;
    logic [EU_SRA_W-1:0]  rs_addr;
    logic [EU_RV_W-1:0]   rv_addr;
  } rr_stage_t;

  typedef struct packed {
    logic                 valid;
    logic [EU_ROB_AW-1:0] rob_addr;
    logic [EU_DRA_W-1:0]  rw_addr;
    logic [EU_SRA_W-1:0]  rs_addr;
    logic [EU_RV_W-1:0]   rv_addr;
    logic [EU_DW-1:0]     result;
  } ex_reg_t;

  function automatic logic [EU_DW-1:0] sext_imm(input logic [EU_IMM_W-1:0] imm);
    return {{(EU_DW-EU_IMM_W){imm[EU_IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/execution_unit_if.sv
// Issue bus from the execution buffer to the execution unit.
// The buffer drives (master); the execution unit consumes (slave). eb_accept travels back as a plain port.
interface execution_buffer_ifc;
  import nand_cpu_pkg::*;

  logic                 valid;
  logic [EU_ROB_AW-1:0] rob_addr;
  AluOp                 alu_op;
  logic [EU_IMM_W-1:0]  immdt;
  logic [EU_DRA_W-1:0]  ra_addr;
  logic [EU_DRA_W-1:0]  rt_addr;
  logic [EU_DRA_W-1:0]  rw_addr;
  logic [EU_RV_W-1:0]   rv_addr;
  logic [EU_SRA_W-1:0]  rs_addr;
  logic                 use_rt;

  modport master (
    output valid, rob_addr, alu_op, immdt, ra_addr, rt_addr, rw_addr, rv_addr, rs_addr, use_rt
  );

  modport slave (
    input valid, rob_addr, alu_op, immdt, ra_addr, rt_addr, rw_addr, rv_addr, rs_addr, use_rt
  );

endinterface

// File: rtl/execution_unit_alu.sv
// Combinational ALU for the execution unit; all arithmetic wraps modulo 2^EU_DW.
// Shifts use the low log2(EU_DW) bits of operand b as the shift amount.
module alu
  import nand_cpu_pkg::*;
(
  input  AluOp             alu_op,
  input  logic [EU_DW-1:0] a,
  input  logic [EU_DW-1:0] b,
  output logic [EU_DW-1:0] result
);

  localparam int SH_W = $clog2(EU_DW);

  logic [SH_W-1:0] shamt;

  assign shamt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NAND: result = ~(a & b);
      ALU_SHL:  result = a << shamt;
      ALU_SHR:  result = a >> shamt;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/execution_unit.sv
// Two-stage (RR, EX) execution unit behind the execution buffer, with write-back and wakeup ports.
// Define EXEC_FWD_EN to add the EX-result bypass into RR and wake dependents one cycle early.
module execution_unit
  import nand_cpu_pkg::*;
#(
  parameter int DW     = EU_DW,
  parameter int ROB_AW = EU_ROB_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  execution_buffer_ifc.slave   eb,
  output logic                 eb_accept,
  input  logic                 flush,
  output logic [EU_DRA_W-1:0]  rf_ra_addr,
  input  logic [DW-1:0]        rf_ra_data,
  output logic [EU_DRA_W-1:0]  rf_rt_addr,
  input  logic [DW-1:0]        rf_rt_data,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [ROB_AW-1:0]    wb_rob_addr,
  output logic [EU_DRA_W-1:0]  wb_rw_addr,
  output logic [DW-1:0]        wb_data,
  output logic [EU_SRA_W-1:0]  wb_rs_addr,
  output logic [EX_FLAG_W-1:0] wb_flags,
  output logic [EU_RV_W-1:0]   wb_rv_addr,
  output logic                 wake_valid,
  output logic [EU_DRA_W-1:0]  wake_addr
);

  // Handshakes: an issue transfers on a cycle with eb.valid & eb_accept (eb_accept never
  // looks at eb.valid); a result transfers on wb_valid & wb_ready, and wb_* hold until then.

  rr_stage_t        rr_q, rr_d;
  ex_reg_t          ex_q, ex_d;
  ex_stage_t        ex_in;
  logic [EU_DW-1:0] alu_result;
  logic [EU_DW-1:0] op_a;
  logic [EU_DW-1:0] rt_val;
  logic             wb_fire;
  logic             rr_adv;

  assign wb_fire    = ex_q.valid & wb_ready;
  assign rr_adv     = ~ex_q.valid | wb_fire;
  // rst gates accept combinationally so it drops the moment reset is asserted.
  assign eb_accept  = ~rst & ~flush & (~rr_q.valid | rr_adv);
  assign rf_ra_addr = eb.ra_addr;
  assign rf_rt_addr = eb.rt_addr;

`ifdef EXEC_FWD_EN
  logic [EU_DRA_W-1:0] rr_ra_addr_q, rr_ra_addr_d;
  logic [EU_DRA_W-1:0] rr_rt_addr_q, rr_rt_addr_d;
  logic                fwd_a, fwd_b;

  always_comb begin
    rr_ra_addr_d = rr_ra_addr_q;
    rr_rt_addr_d = rr_rt_addr_q;
    if (eb.valid && eb_accept) begin
      rr_ra_addr_d = eb.ra_addr;
      rr_rt_addr_d = eb.rt_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ra_addr_q <= '0;
      rr_rt_addr_q <= '0;
    end else begin
      rr_ra_addr_q <= rr_ra_addr_d;
      rr_rt_addr_q <= rr_rt_addr_d;
    end
  end

  // The EX register holds the youngest older result, so it wins over register-file data.
  assign fwd_a      = ex_q.valid & (rr_ra_addr_q == ex_q.rw_addr);
  assign fwd_b      = ex_q.valid & (rr_rt_addr_q == ex_q.rw_addr);
  assign op_a       = fwd_a ? ex_q.result : rr_q.ra_data;
  assign rt_val     = fwd_b ? ex_q.result : rr_q.rt_data;
  assign wake_valid = rr_q.valid & rr_adv & ~flush;
  assign wake_addr  = rr_q.rw_addr;
`else
  assign op_a       = rr_q.ra_data;
  assign rt_val     = rr_q.rt_data;
  assign wake_valid = wb_fire;
  assign wake_addr  = ex_q.rw_addr;
`endif

  always_comb begin
    ex_in          = '0;
    ex_in.valid    = rr_q.valid;
    ex_in.rob_addr = rr_q.rob_addr;
    ex_in.alu_op   = rr_q.alu_op;
    ex_in.a        = op_a;
    ex_in.b        = rr_q.use_rt ? rt_val : sext_imm(rr_q.immdt);
    ex_in.rw_addr  = rr_q.rw_addr;
    ex_in.rs_addr  = rr_q.rs_addr;
    ex_in.rv_addr  = rr_q.rv_addr;
  end

  alu u_alu (
    .alu_op (ex_in.alu_op),
    .a      (ex_in.a),
    .b      (ex_in.b),
    .result (alu_result)
  );

  always_comb begin
    rr_d = rr_q;
    if (flush) begin
      rr_d.valid = 1'b0;
    end else if (eb_accept) begin
      rr_d.valid = eb.valid;
      if (eb.valid) begin
        rr_d.rob_addr = eb.rob_addr;
        rr_d.alu_op   = eb.alu_op;
        rr_d.use_rt   = eb.use_rt;
        rr_d.immdt    = eb.immdt;
        rr_d.ra_data  = rf_ra_data;
        rr_d.rt_data  = rf_rt_data;
        rr_d.rw_addr  = eb.rw_addr;
        rr_d.rs_addr  = eb.rs_addr;
        rr_d.rv_addr  = eb.rv_addr;
      end
    end
  end

  // A write-back firing in a flush cycle still completes; only the stage valids are squashed.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d.valid = 1'b0;
    end else if (rr_adv) begin
      ex_d.valid = ex_in.valid;
      if (ex_in.valid) begin
        ex_d.rob_addr = ex_in.rob_addr;
        ex_d.rw_addr  = ex_in.rw_addr;
        ex_d.rs_addr  = ex_in.rs_addr;
        ex_d.rv_addr  = ex_in.rv_addr;
        ex_d.result   = alu_result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
      ex_q <= '0;
    end else begin
      rr_q <= rr_d;
      ex_q <= ex_d;
    end
  end

  assign wb_valid    = ex_q.valid;
  assign wb_rob_addr = ex_q.rob_addr;
  assign wb_rw_addr  = ex_q.rw_addr;
  assign wb_data     = ex_q.result;
  assign wb_rs_addr  = ex_q.rs_addr;
  assign wb_rv_addr  = ex_q.rv_addr;
  assign wb_flags    = {ex_q.result[EU_DW-1], (ex_q.result == '0)};

endmodule

// File: tb/tb_execution_unit.sv
// Directed plus randomized bench for execution_unit: program-order register model,
// expected write-back queue, and a single summary line at the end.
`timescale 1ns/1ps
module tb_execution_unit;
  import nand_cpu_pkg::*;

  localparam int W = EU_ROB_AW + EU_DRA_W + EU_SRA_W + EU_RV_W + EU_DW + EX_FLAG_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 eb_accept;
  logic [EU_DRA_W-1:0]  rf_ra_addr, rf_rt_addr;
  logic [EU_DW-1:0]     rf_ra_data, rf_rt_data;
  logic                 wb_valid, wb_ready;
  logic [EU_ROB_AW-1:0] wb_rob_addr;
  logic [EU_DRA_W-1:0]  wb_rw_addr;
  logic [EU_DW-1:0]     wb_data;
  logic [EU_SRA_W-1:0]  wb_rs_addr;
  logic [EX_FLAG_W-1:0] wb_flags;
  logic [EU_RV_W-1:0]   wb_rv_addr;
  logic                 wake_valid;
  logic [EU_DRA_W-1:0]  wake_addr;

  execution_buffer_ifc eb_if();

  execution_unit dut (
    .clk         (clk),
    .rst         (rst),
    .eb          (eb_if),
    .eb_accept   (eb_accept),
    .flush       (flush),
    .rf_ra_addr  (rf_ra_addr),
    .rf_ra_data  (rf_ra_data),
    .rf_rt_addr  (rf_rt_addr),
    .rf_rt_data  (rf_rt_data),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rob_addr (wb_rob_addr),
    .wb_rw_addr  (wb_rw_addr),
    .wb_data     (wb_data),
    .wb_rs_addr  (wb_rs_addr),
    .wb_flags    (wb_flags),
    .wb_rv_addr  (wb_rv_addr),
    .wake_valid  (wake_valid),
    .wake_addr   (wake_addr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- register file and models ----------------
  logic [EU_DW-1:0] rf   [EU_NUM_D_REG];
  logic [EU_DW-1:0] arch [EU_NUM_D_REG];

  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rt_data = rf[rf_rt_addr];

  logic [W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int fires  = 0;
  int nacc;
  int base;

  logic                 rand_ready;
  logic [EU_ROB_AW-1:0] rob_tag;
  logic                 s_wb_valid, s_eb_accept, s_wake_valid, s_fire, s_acc;
  logic [EU_DW-1:0]     s_wb_data;
  logic [EX_FLAG_W-1:0] s_wb_flags;
  logic [EU_DRA_W-1:0]  s_wake_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EU_DW-1:0] ref_alu(input AluOp op, input logic [EU_DW-1:0] a,
                                               input logic [EU_DW-1:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NAND: return ~(a & b);
      ALU_SHL:  return a << b[3:0];
      ALU_SHR:  return a >> b[3:0];
      default:  return '0;
    endcase
  endfunction

  // Program-order semantics: each accepted instruction sees all older results.
  task automatic model_issue();
    logic [EU_DW-1:0] a, b, r;
    a = arch[eb_if.ra_addr];
    b = eb_if.use_rt ? arch[eb_if.rt_addr] : {{10{eb_if.immdt[5]}}, eb_if.immdt};
    r = ref_alu(eb_if.alu_op, a, b);
    arch[eb_if.rw_addr] = r;
    exp_q.push_back({eb_if.rob_addr, eb_if.rw_addr, eb_if.rs_addr, eb_if.rv_addr, r,
                     r[EU_DW-1], (r == '0)});
  endtask

  task automatic set_reg(input int idx, input logic [EU_DW-1:0] v);
    rf[idx]   = v;
    arch[idx] = v;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [W-1:0]        got, exp;
    logic [EU_DRA_W-1:0] f_rw;
    logic [EU_DW-1:0]    f_data;
    @(negedge clk);
    s_wb_valid   = wb_valid;
    s_wb_data    = wb_data;
    s_wb_flags   = wb_flags;
    s_eb_accept  = eb_accept;
    s_wake_valid = wake_valid;
    s_wake_addr  = wake_addr;
    s_fire       = wb_valid & wb_ready;
    s_acc        = eb_if.valid & eb_accept;
    f_rw         = wb_rw_addr;
    f_data       = wb_data;
    if (s_fire) begin
      fires++;
      got = {wb_rob_addr, wb_rw_addr, wb_rs_addr, wb_rv_addr, wb_data, wb_flags};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      check("wb_result", got, exp);
    end
    if (flush) exp_q.delete();
    if (s_acc) model_issue();
    @(posedge clk);
    #1;
    if (s_fire) rf[f_rw] = f_data;
    if (rand_ready) wb_ready = ($urandom_range(0, 99) < 60);
  endtask

  task automatic set_instr(input AluOp op, input logic [2:0] ra, input logic [2:0] rt,
                           input logic [2:0] rw, input logic use_rt, input logic [5:0] imm);
    eb_if.valid    = 1'b1;
    eb_if.rob_addr = rob_tag;
    eb_if.alu_op   = op;
    eb_if.ra_addr  = ra;
    eb_if.rt_addr  = rt;
    eb_if.rw_addr  = rw;
    eb_if.use_rt   = use_rt;
    eb_if.immdt    = imm;
    eb_if.rs_addr  = EU_SRA_W'($urandom_range(0, 3));
    eb_if.rv_addr  = EU_RV_W'($urandom);
  endtask

  // Sources r0-r3, destinations r4-r7: independent instructions with no hazards.
  task automatic set_rand_instr();
    set_instr(AluOp'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
              3'($urandom_range(4, 7)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
  endtask

  task automatic wait_accept(input string tag);
    int guard = 0;
    do begin
      tick();
      guard++;
    end while (!s_acc && guard < 50);
    check(tag, s_acc, 1'b1);
    rob_tag = ~rob_tag;
  endtask

  task automatic issue_one(input AluOp op, input logic [2:0] ra, input logic [2:0] rt,
                           input logic [2:0] rw, input logic use_rt, input logic [5:0] imm);
    set_instr(op, ra, rt, rw, use_rt, imm);
    wait_accept("issue_accepted");
  endtask

  task automatic drain();
    int guard = 0;
    eb_if.valid = 1'b0;
    rand_ready  = 1'b0;
    wb_ready    = 1'b1;
    while ((exp_q.size() != 0 || wb_valid) && guard < 40) begin
      tick();
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b1; rand_ready = 1'b0; rob_tag = '0;
    eb_if.valid = 1'b0; eb_if.rob_addr = '0; eb_if.alu_op = ALU_ADD; eb_if.immdt = '0;
    eb_if.ra_addr = '0; eb_if.rt_addr = '0; eb_if.rw_addr = '0; eb_if.rv_addr = '0;
    eb_if.rs_addr = '0; eb_if.use_rt = 1'b0;
    for (int i = 0; i < EU_NUM_D_REG; i++) set_reg(i, EU_DW'($urandom));

    // Reset state
    @(posedge clk); #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wake_valid", wake_valid, 0);
    check("rst_eb_accept", eb_accept, 0);
    check("rst_wb_data", wb_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check("idle_eb_accept", s_eb_accept, 1);
    check("idle_wb_valid", s_wb_valid, 0);

    // 1: NAND latency and flags
    set_reg(2, 16'h00FF); set_reg(3, 16'hF0F0);
    issue_one(ALU_NAND, 3'd2, 3'd3, 3'd5, 1'b1, 6'd0);
    eb_if.valid = 1'b0;
    tick(); check("t1_lat_cycle1", s_wb_valid, 0);
    tick(); check("t1_lat_cycle2", s_wb_valid, 1);
    check("t1_data", s_wb_data, 16'hFF0F);
    check("t1_flags", s_wb_flags, 2'b10);
    drain();

    // 2: immediate -1 added to 1
    set_reg(2, 16'h0001);
    issue_one(ALU_ADD, 3'd2, 3'd0, 3'd6, 1'b0, 6'b111111);
    eb_if.valid = 1'b0;
    tick(); tick();
    check("t2_wb_valid", s_wb_valid, 1);
    check("t2_data", s_wb_data, 16'h0000);
    check("t2_flags", s_wb_flags, 2'b01);
    drain();

    // 3: back-to-back issue against 4 cycles of backpressure
    base = fires; nacc = 0;
    wb_ready = 1'b0;
    set_rand_instr();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_acc) begin nacc++; rob_tag = ~rob_tag; set_rand_instr(); end
      if (i >= 2) begin
        check("t3_stall_accept", s_eb_accept, 0);
        check("t3_stall_valid", s_wb_valid, 1);
        check("t3_stall_data", s_wb_data, exp_q[0][17:2]);
      end
    end
    check("t3_accepts_before_stall", nacc, 2);
    wb_ready = 1'b1;
    for (int guard = 0; guard < 40 && nacc < 6; guard++) begin
      tick();
      if (s_acc) begin
        nacc++; rob_tag = ~rob_tag;
        if (nacc < 6) set_rand_instr();
      end
    end
    eb_if.valid = 1'b0;
    drain();
    check("t3_total_wb", fires - base, 6);

    // 4: flush with both stages full and a same-cycle issue
    wb_ready = 1'b0;
    issue_one(ALU_XOR, 3'd0, 3'd1, 3'd5, 1'b1, 6'd0);
    issue_one(ALU_OR,  3'd2, 3'd3, 3'd6, 1'b1, 6'd0);
    set_rand_instr();
    flush = 1'b1;
    base = fires;
    tick();
    check("t4_flush_accept", s_eb_accept, 0);
    flush = 1'b0; eb_if.valid = 1'b0; wb_ready = 1'b1;
    tick(); check("t4_after_wb_valid", s_wb_valid, 0);
    tick(); check("t4_after2_wb_valid", s_wb_valid, 0);
    check("t4_nothing_written", fires - base, 0);

    // 4b: flush coinciding with a write-back
    wb_ready = 1'b0;
    issue_one(ALU_SUB, 3'd1, 3'd2, 3'd7, 1'b1, 6'd0);
    issue_one(ALU_AND, 3'd3, 3'd0, 3'd4, 1'b1, 6'd0);
    flush = 1'b1; wb_ready = 1'b1; eb_if.valid = 1'b0;
    base = fires;
    tick();
    check("t4b_fire_in_flush", s_fire, 1);
    flush = 1'b0;
    tick(); check("t4b_after_wb_valid", s_wb_valid, 0);
    check("t4b_one_written", fires - base, 1);
    drain();

    // 5: dependent pair r1 <- r2 + r3 ; r4 <- r1 + r1
    set_reg(2, EU_DW'($urandom)); set_reg(3, EU_DW'($urandom));
`ifdef EXEC_FWD_EN
    issue_one(ALU_ADD, 3'd2, 3'd3, 3'd1, 1'b1, 6'd0);
    issue_one(ALU_ADD, 3'd1, 3'd1, 3'd4, 1'b1, 6'd0);
    check("t5_fwd_wake_valid", s_wake_valid, 1);
    check("t5_fwd_wake_addr", s_wake_addr, 1);
    drain();
`else
    issue_one(ALU_ADD, 3'd2, 3'd3, 3'd1, 1'b1, 6'd0);
    eb_if.valid = 1'b0;
    tick(); check("t5_no_early_wake", s_wake_valid, 0);
    tick(); check("t5_wake_valid", s_wake_valid, 1);
    check("t5_wake_addr", s_wake_addr, 1);
    issue_one(ALU_ADD, 3'd1, 3'd1, 3'd4, 1'b1, 6'd0);
    drain();
`endif

    // 6: asynchronous reset in the middle of a stall
    wb_ready = 1'b0;
    issue_one(ALU_ADD, 3'd0, 3'd1, 3'd5, 1'b1, 6'd0);
    issue_one(ALU_SUB, 3'd2, 3'd3, 3'd6, 1'b1, 6'd0);
    set_rand_instr();
    tick();
    check("t6_pre_wb_valid", s_wb_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_wb_valid", wb_valid, 0);
    check("t6_rst_wake_valid", wake_valid, 0);
    check("t6_rst_eb_accept", eb_accept, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; eb_if.valid = 1'b0; wb_ready = 1'b1;
    base = fires;
    tick();
    check("t6_post_wb_valid", s_wb_valid, 0);
    check("t6_post_eb_accept", s_eb_accept, 1);
    tick();
    check("t6_post2_wb_valid", s_wb_valid, 0);
    check("t6_pipe_empty", fires - base, 0);

    // 7: random stream with random backpressure and issue gaps
    base = fires;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        eb_if.valid = 1'b0;
        tick();
      end
      set_rand_instr();
      wait_accept("rand_accepted");
    end
    drain();
    check("t7_total_wb", fires - base, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
